// File: rtl/mem_burst_ctrl.sv
// Memory-interface sequencer: accepts a master request in IDLE and drives a
// synchronous SRAM-style port through single/burst reads or a single write.
module mem_burst_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned WAIT_CYC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic              burst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ack,
  output logic              busy,
  output logic              oe,
  output logic              we,
  output logic              we_me,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rlast
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WAIT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BURST = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [BEAT_W-1:0] r_beat,      w_beat_nxt;
  logic [BEAT_W-1:0] r_last_beat, w_last_beat_nxt;
  logic [WAIT_W-1:0] r_wait,      w_wait_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
  logic              r_rvalid,    w_rvalid_nxt;
  logic              r_rlast,     w_rlast_nxt;
  logic              w_idle;
  logic              w_beat_end;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_beat_end = (r_wait == LAST_WAIT);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_last_beat <= '0;
      r_wait      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_last_beat <= w_last_beat_nxt;
      r_wait      <= w_wait_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_rlast     <= w_rlast_nxt;
    end
  end

  // Next-state and next-datapath decode
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_last_beat_nxt = r_last_beat;
    w_wait_nxt      = r_wait;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rdata_nxt     = r_rdata;
    w_rvalid_nxt    = 1'b0;
    w_rlast_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_mem_addr_nxt  = addr;
          w_mem_wdata_nxt = wdata;
          w_beat_nxt      = '0;
          w_wait_nxt      = '0;
          w_last_beat_nxt = (rw && burst) ? LAST_BURST : BEAT_W'(0);
          w_state_nxt     = rw ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        if (w_beat_end) begin
          w_rdata_nxt    = mem_rdata;
          w_rvalid_nxt   = 1'b1;
          w_rlast_nxt    = (r_beat == r_last_beat);
          w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
          w_wait_nxt     = '0;
          if (r_beat == r_last_beat) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_WRITE: begin
        if (w_beat_end) begin
          w_wait_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode from the state register; ack/we_me are the Mealy terms
  assign busy      = !w_idle;
  assign oe        = (r_state == ST_READ);
  assign we        = (r_state == ST_WRITE);
  assign ack       = reset && w_idle && req;
  assign we_me     = ack && !rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign rlast     = r_rlast;

endmodule
